wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Register-file write-port arbiter and pending-write scoreboard. Merges single-cycle pipeline writeback with results from a multicycle execution unit (mul/div) onto the regfile's single write port (`load`/`dest`/`in`). Tracks destinations with outstanding multicycle results so the decode stage can stall on RAW hazards. Sits between the writeback stage/multicycle unit and `regfile`.

## Interface
Parameters:
- `QDEPTH`, 4: multicycle result queue depth; power of two, at least 2.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `pipe_valid`  in  1  pipeline writeback request this cycle. Highest priority; never back-pressured.
- `pipe_dest`  in  5  pipeline destination register.
- `pipe_data`  in  32  pipeline writeback data.
- `mc_valid`  in  1  multicycle result valid.
- `mc_ready`  out  1  queue can accept a result; equals `count < QDEPTH`.
- `mc_dest`  in  5  multicycle destination register.
- `mc_data`  in  32  multicycle result data.
- `issue_valid`  in  1  multicycle op issued this cycle; marks `issue_dest` pending.
- `issue_dest`  in  5  destination of the issued op.
- `busy_src_a`, `busy_src_b`  in  5 each  scoreboard query addresses.
- `busy_a`, `busy_b`  out  1 each  combinational; set when the queried register is pending. Always 0 for x0.
- `count`  out  $clog2(QDEPTH)+1  current queue occupancy.
- `rf_load`  out  1  regfile write enable (registered).
- `rf_dest`  out  5  regfile write address (registered).
- `rf_in`  out  32  regfile write data (registered).

## Operation
- Queue: a circular FIFO of {dest, data} with QDEPTH entries, plus read/write pointers and a count.
  - A push occurs when `mc_valid && mc_ready`.
  - Pointers wrap modulo QDEPTH.
- Output register selection, evaluated each cycle with the first matching rule taking effect:
  1. If `pipe_valid` is set, load `{1, pipe_dest, pipe_data}`.
  2. Otherwise, if the queue is not empty, pop the head and load `{1, head.dest, head.data}`.
  3. Otherwise, if the bypass is applicable (see Configuration), load `{1, mc_dest, mc_data}` and do not push.
  4. Otherwise, load `{0, last dest, last data}`: `rf_load` is 0, and `rf_dest` and `rf_in` hold their previous values.
- Destination x0: any selected write with dest 0 drives `rf_load` = 0. The queue entry is still consumed.
- Simultaneous push and pop in the same cycle: `count` is unchanged. A push is allowed when full only if a pop occurs in the same cycle? No: `mc_ready` depends only on `count`, so no push is accepted when full.
- Scoreboard: a 32-bit `pending` vector. Bit 0 is forced to 0.
  - Set: bit `issue_dest` when `issue_valid` is set and `issue_dest` is not 0.
  - Clear: bit d when a multicycle result with dest d is selected into the output register, by pop or by bypass.
  - Same bit set and cleared in the same cycle: set wins, because it belongs to a newer op.
  - Pipeline writes never touch `pending`.
- Reset: asynchronous. Clears the queue, pointers, `count`, `pending`, `rf_load`, `rf_dest` and `rf_in`.
  - After reset, outputs are `rf_load`=0, `rf_dest`=0, `rf_in`=0, `mc_ready`=1, `count`=0, `busy_a`=`busy_b`=0.
  - Reset asserted mid-operation discards all queued results.

## Timing
- Pipeline write: `pipe_valid` in cycle t gives `rf_load` in cycle t+1, and the regfile captures the data at the end of t+1.
- Multicycle result latency, with an empty queue and idle pipeline:
  - Without the bypass: accepted at t, `rf_load` at t+2.
  - With the bypass: `rf_load` at t+1.
- A queued result stalls one cycle for every cycle in which `pipe_valid` is high.
- `busy_*` falls in the same cycle that `rf_load` rises for that register. The regfile's internal write-through makes the value readable in that same cycle.
- `mc_ready` is a function of registered `count` only; there is no combinational path from `mc_valid`.

## Configuration
- Macro: `WB_MC_BYPASS_EN`.
- Defined: when the queue is empty and `pipe_valid` is 0, an accepted multicycle result goes straight to the output register and is not pushed. This is the 1-cycle path.
- Undefined: every accepted result is pushed. Minimum latency is 2 cycles; the rest of the behaviour is identical.

## Test plan
- Reset release, pipeline write: `pipe_valid`=1, `pipe_dest`=5, `pipe_data`=0xDEADBEEF -> next cycle `rf_load`=1, `rf_dest`=5, `rf_in`=0xDEADBEEF.
- Scoreboard: `issue_valid` with `issue_dest`=7 -> `busy_a`=1 for src 7.
  - Then an mc result (7, 0x42) with pipeline idle -> `rf_load` with 0x42 at t+2 (t+1 with the bypass), and `busy_a` returns to 0 in that cycle.
- Priority and queueing: `pipe_valid` held high for 6 cycles while 5 mc results are offered, QDEPTH=4.
  - `mc_ready` drops after 4 accepts, and `count`=4.
  - Results drain in FIFO order after `pipe_valid` falls, one per cycle, with pointer wrap-around exercised.
- x0 handling:
  - mc result with dest 0 -> consumed, `count` decrements, `rf_load`=0.
  - `issue_dest`=0 -> `busy` stays 0.
- Same-cycle set and clear on register 9 (pop of reg 9 with a new issue to reg 9) -> `busy` for 9 remains 1.
- `rst_n` asserted with 3 queued entries and pending bits {3,4} -> immediately `count`=0, `mc_ready`=1, `busy`=0, `rf_load`=0. No stale writes occur after release.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Bus bundle for wb_arbiter: pipeline writeback, multicycle result, issue,
// scoreboard query and regfile write-port signals.
interface wb_arbiter_if #(
    parameter int unsigned QDEPTH = 4
);
    localparam int unsigned CW = $clog2(QDEPTH) + 1;

    logic          pipe_valid;
    logic [4:0]    pipe_dest;
    logic [31:0]   pipe_data;
    logic          mc_valid;
    logic          mc_ready;
    logic [4:0]    mc_dest;
    logic [31:0]   mc_data;
    logic          issue_valid;
    logic [4:0]    issue_dest;
    logic [4:0]    busy_src_a;
    logic [4:0]    busy_src_b;
    logic          busy_a;
    logic          busy_b;
    logic [CW-1:0] count;
    logic          rf_load;
    logic [4:0]    rf_dest;
    logic [31:0]   rf_in;

    modport master (
        output pipe_valid, pipe_dest, pipe_data,
        output mc_valid, mc_dest, mc_data,
        output issue_valid, issue_dest, busy_src_a, busy_src_b,
        input  mc_ready, busy_a, busy_b, count, rf_load, rf_dest, rf_in
    );

    modport slave (
        input  pipe_valid, pipe_dest, pipe_data,
        input  mc_valid, mc_dest, mc_data,
        input  issue_valid, issue_dest, busy_src_a, busy_src_b,
        output mc_ready, busy_a, busy_b, count, rf_load, rf_dest, rf_in
    );
endinterface

// File: rtl/wb_arbiter.sv
// Regfile write-port arbiter with multicycle result FIFO and pending-write scoreboard.
// Define WB_MC_BYPASS_EN to let a result skip the empty FIFO (1-cycle latency).
module wb_arbiter #(
    parameter int unsigned QDEPTH = 4
) (
    input logic        clk,
    input logic        rst_n,
    wb_arbiter_if.slave bus
);
    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;

    logic [4:0]    q_dest [QDEPTH];
    logic [31:0]   q_data [QDEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic [31:0]   pending_q;
    logic [31:0]   pending_d;

    logic          rf_load_q;
    logic [4:0]    rf_dest_q;
    logic [31:0]   rf_in_q;

    logic          mc_ready;
    logic          empty;
    logic          accept;
    logic          bypass;
    logic          push;
    logic          pop;

    logic          sel_valid;
    logic [4:0]    sel_dest;
    logic [31:0]   sel_data;
    logic          clr_en;
    logic [4:0]    clr_dest;

    assign empty    = (count_q == '0);
    assign mc_ready = (count_q < CW'(QDEPTH));
    assign accept   = bus.mc_valid && mc_ready;

`ifdef WB_MC_BYPASS_EN
    assign bypass = accept && empty && !bus.pipe_valid;
`else
    assign bypass = 1'b0;
`endif

    assign push = accept && !bypass;
    assign pop  = !bus.pipe_valid && !empty;

    always_comb begin
        sel_valid = 1'b0;
        sel_dest  = rf_dest_q;
        sel_data  = rf_in_q;
        clr_en    = 1'b0;
        clr_dest  = '0;
        if (bus.pipe_valid) begin
            sel_valid = 1'b1;
            sel_dest  = bus.pipe_dest;
            sel_data  = bus.pipe_data;
        end else if (pop) begin
            sel_valid = 1'b1;
            sel_dest  = q_dest[rd_ptr];
            sel_data  = q_data[rd_ptr];
            clr_en    = 1'b1;
            clr_dest  = q_dest[rd_ptr];
        end else if (bypass) begin
            sel_valid = 1'b1;
            sel_dest  = bus.mc_dest;
            sel_data  = bus.mc_data;
            clr_en    = 1'b1;
            clr_dest  = bus.mc_dest;
        end
    end

    // Clear before set: a same-cycle issue to the retiring register belongs to a newer op.
    always_comb begin
        pending_d = pending_q;
        if (clr_en) begin
            pending_d[clr_dest] = 1'b0;
        end
        if (bus.issue_valid && (bus.issue_dest != '0)) begin
            pending_d[bus.issue_dest] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                q_dest[PW'(i)] <= '0;
                q_data[PW'(i)] <= '0;
            end
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                q_dest[wr_ptr] <= bus.mc_dest;
                q_data[wr_ptr] <= bus.mc_data;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_load_q <= 1'b0;
            rf_dest_q <= '0;
            rf_in_q   <= '0;
            pending_q <= '0;
        end else begin
            rf_load_q <= sel_valid && (sel_dest != '0);
            rf_dest_q <= sel_dest;
            rf_in_q   <= sel_data;
            pending_q <= pending_d;
        end
    end

    assign bus.mc_ready = mc_ready;
    assign bus.count    = count_q;
    assign bus.rf_load  = rf_load_q;
    assign bus.rf_dest  = rf_dest_q;
    assign bus.rf_in    = rf_in_q;
    assign bus.busy_a   = (bus.busy_src_a != '0) && pending_q[bus.busy_src_a];
    assign bus.busy_b   = (bus.busy_src_b != '0) && pending_q[bus.busy_src_b];
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_wb_arbiter;
    localparam int QD = 4;
    localparam int CW = $clog2(QD) + 1;
`ifdef WB_MC_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [4:0]  d;
        logic [31:0] v;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    ent_t        mq[$];
    bit   [31:0] m_pend;
    bit          m_load;
    logic [4:0]  m_dest;
    logic [31:0] m_in;

    wb_arbiter_if #(.QDEPTH(QD)) bus ();
    wb_arbiter #(.QDEPTH(QD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.pipe_valid  = 1'b0;
        bus.pipe_dest   = '0;
        bus.pipe_data   = '0;
        bus.mc_valid    = 1'b0;
        bus.mc_dest     = '0;
        bus.mc_data     = '0;
        bus.issue_valid = 1'b0;
        bus.issue_dest  = '0;
        bus.busy_src_a  = '0;
        bus.busy_src_b  = '0;
    endtask

    task automatic model_reset();
        mq.delete();
        m_pend = '0;
        m_load = 1'b0;
        m_dest = '0;
        m_in   = '0;
    endtask

    // Reference: priority pipe > FIFO head > (optional) bypass; FIFO capacity QD.
    task automatic model_step();
        bit   acc;
        bit   taken;
        ent_t e;
        acc   = bus.mc_valid && (mq.size() < QD);
        taken = 1'b0;
        if (bus.pipe_valid) begin
            m_load = (bus.pipe_dest != 0);
            m_dest = bus.pipe_dest;
            m_in   = bus.pipe_data;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            m_load = (e.d != 0);
            m_dest = e.d;
            m_in   = e.v;
            m_pend[e.d] = 1'b0;
        end else if (BYP && acc) begin
            taken  = 1'b1;
            m_load = (bus.mc_dest != 0);
            m_dest = bus.mc_dest;
            m_in   = bus.mc_data;
            m_pend[bus.mc_dest] = 1'b0;
        end else begin
            m_load = 1'b0;
        end
        if (acc && !taken) begin
            e.d = bus.mc_dest;
            e.v = bus.mc_data;
            mq.push_back(e);
        end
        if (bus.issue_valid && bus.issue_dest != 0) m_pend[bus.issue_dest] = 1'b1;
        m_pend[0] = 1'b0;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.rf_load !== 1'b0) begin failures++; $display("FAIL reset_rf_load got=%b exp=0", bus.rf_load); end
        checks++; if (bus.rf_dest !== 5'd0) begin failures++; $display("FAIL reset_rf_dest got=%0d exp=0", bus.rf_dest); end
        checks++; if (bus.rf_in !== 32'd0) begin failures++; $display("FAIL reset_rf_in got=%h exp=0", bus.rf_in); end
        checks++; if (bus.mc_ready !== 1'b1) begin failures++; $display("FAIL reset_mc_ready got=%b exp=1", bus.mc_ready); end
        checks++; if (bus.count !== CW'(0)) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        checks++; if (bus.busy_a !== 1'b0 || bus.busy_b !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b%b exp=00", bus.busy_a, bus.busy_b); end
        rst_n = 1'b1;
    endtask

    task automatic test_pipe_write();
        bus.pipe_valid = 1'b1;
        bus.pipe_dest  = 5'd5;
        bus.pipe_data  = 32'hDEADBEEF;
        cycle();
        bus.pipe_valid = 1'b0;
        checks++; if (bus.rf_load !== 1'b1) begin failures++; $display("FAIL pipe_load got=%b exp=1", bus.rf_load); end
        checks++; if (bus.rf_dest !== 5'd5) begin failures++; $display("FAIL pipe_dest got=%0d exp=5", bus.rf_dest); end
        checks++; if (bus.rf_in !== 32'hDEADBEEF) begin failures++; $display("FAIL pipe_data got=%h exp=deadbeef", bus.rf_in); end
    endtask

    task automatic test_scoreboard();
        bus.issue_valid = 1'b1;
        bus.issue_dest  = 5'd7;
        cycle();
        bus.issue_valid = 1'b0;
        bus.busy_src_a  = 5'd7;
        #1;
        checks++; if (bus.busy_a !== 1'b1) begin failures++; $display("FAIL sb_busy_set got=%b exp=1", bus.busy_a); end
        bus.mc_valid = 1'b1;
        bus.mc_dest  = 5'd7;
        bus.mc_data  = 32'h42;
        cycle();
        bus.mc_valid = 1'b0;
`ifndef WB_MC_BYPASS_EN
        checks++; if (bus.rf_load !== 1'b0) begin failures++; $display("FAIL sb_t1_load got=%b exp=0", bus.rf_load); end
        checks++; if (bus.busy_a !== 1'b1) begin failures++; $display("FAIL sb_t1_busy got=%b exp=1", bus.busy_a); end
        checks++; if (bus.count !== CW'(1)) begin failures++; $display("FAIL sb_t1_count got=%0d exp=1", bus.count); end
        cycle();
`endif
        checks++; if (bus.rf_load !== 1'b1 || bus.rf_dest !== 5'd7) begin failures++; $display("FAIL sb_wb_load got=%b/%0d exp=1/7", bus.rf_load, bus.rf_dest); end
        checks++; if (bus.rf_in !== 32'h42) begin failures++; $display("FAIL sb_wb_data got=%h exp=42", bus.rf_in); end
        checks++; if (bus.busy_a !== 1'b0) begin failures++; $display("FAIL sb_busy_clear got=%b exp=0", bus.busy_a); end
    endtask

    task automatic test_priority_queue();
        logic [31:0] vals [5];
        logic [31:0] pd;
        int k = 0;
        bit acc;
        for (int i = 0; i < 5; i++) vals[i] = $urandom;
        for (int c = 0; c < 6; c++) begin
            pd = $urandom;
            bus.pipe_valid = 1'b1;
            bus.pipe_dest  = 5'(1 + $urandom_range(0, 30));
            bus.pipe_data  = pd;
            bus.mc_valid   = (k < 5);
            bus.mc_dest    = 5'(10 + k);
            bus.mc_data    = vals[k < 5 ? k : 4];
            acc = bus.mc_valid && bus.mc_ready;
            cycle();
            if (acc) k++;
            checks++; if (bus.rf_in !== pd || bus.rf_load !== 1'b1) begin failures++; $display("FAIL prio_pipe c=%0d got=%b/%h exp=1/%h", c, bus.rf_load, bus.rf_in, pd); end
        end
        checks++; if (bus.count !== CW'(4)) begin failures++; $display("FAIL prio_full_count got=%0d exp=4", bus.count); end
        checks++; if (bus.mc_ready !== 1'b0) begin failures++; $display("FAIL prio_full_ready got=%b exp=0", bus.mc_ready); end
        bus.pipe_valid = 1'b0;
        bus.mc_valid   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (bus.rf_load !== 1'b1 || bus.rf_dest !== 5'(10 + i) || bus.rf_in !== vals[i]) begin
                failures++;
                $display("FAIL prio_drain i=%0d got=%b/%0d/%h exp=1/%0d/%h", i, bus.rf_load, bus.rf_dest, bus.rf_in, 10 + i, vals[i]);
            end
        end
        checks++; if (bus.count !== CW'(0)) begin failures++; $display("FAIL prio_drain_count got=%0d exp=0", bus.count); end
    endtask

    task automatic test_x0();
        bus.pipe_valid = 1'b1;
        bus.pipe_dest  = 5'd3;
        bus.pipe_data  = $urandom;
        bus.mc_valid   = 1'b1;
        bus.mc_dest    = 5'd0;
        bus.mc_data    = $urandom;
        cycle();
        bus.pipe_valid = 1'b0;
        bus.mc_valid   = 1'b0;
        checks++; if (bus.count !== CW'(1)) begin failures++; $display("FAIL x0_queued got=%0d exp=1", bus.count); end
        cycle();
        checks++; if (bus.count !== CW'(0)) begin failures++; $display("FAIL x0_consumed got=%0d exp=0", bus.count); end
        checks++; if (bus.rf_load !== 1'b0) begin failures++; $display("FAIL x0_load got=%b exp=0", bus.rf_load); end
        bus.issue_valid = 1'b1;
        bus.issue_dest  = 5'd0;
        cycle();
        bus.issue_valid = 1'b0;
        bus.busy_src_a  = 5'd0;
        #1;
        checks++; if (bus.busy_a !== 1'b0) begin failures++; $display("FAIL x0_busy got=%b exp=0", bus.busy_a); end
    endtask

    task automatic test_same_cycle();
        bus.issue_valid = 1'b1;
        bus.issue_dest  = 5'd9;
        cycle();
        bus.issue_valid = 1'b0;
        bus.pipe_valid  = 1'b1;
        bus.pipe_dest   = 5'd1;
        bus.pipe_data   = $urandom;
        bus.mc_valid    = 1'b1;
        bus.mc_dest     = 5'd9;
        bus.mc_data     = 32'h0000_0909;
        cycle();
        bus.pipe_valid  = 1'b0;
        bus.mc_valid    = 1'b0;
        bus.issue_valid = 1'b1;
        bus.issue_dest  = 5'd9;
        cycle();
        bus.issue_valid = 1'b0;
        bus.busy_src_b  = 5'd9;
        #1;
        checks++; if (bus.rf_load !== 1'b1 || bus.rf_dest !== 5'd9 || bus.rf_in !== 32'h909) begin failures++; $display("FAIL same_wb got=%b/%0d/%h exp=1/9/909", bus.rf_load, bus.rf_dest, bus.rf_in); end
        checks++; if (bus.busy_b !== 1'b1) begin failures++; $display("FAIL same_busy got=%b exp=1", bus.busy_b); end
    endtask

    task automatic test_reset_mid();
        for (int r = 3; r <= 4; r++) begin
            bus.issue_valid = 1'b1;
            bus.issue_dest  = 5'(r);
            cycle();
        end
        bus.issue_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.pipe_valid = 1'b1;
            bus.pipe_dest  = 5'd2;
            bus.pipe_data  = $urandom;
            bus.mc_valid   = 1'b1;
            bus.mc_dest    = 5'(20 + i);
            bus.mc_data    = $urandom;
            cycle();
        end
        bus.pipe_valid = 1'b0;
        bus.mc_valid   = 1'b0;
        bus.busy_src_a = 5'd3;
        bus.busy_src_b = 5'd4;
        #1;
        checks++; if (bus.count !== CW'(3) || bus.busy_a !== 1'b1) begin failures++; $display("FAIL rstmid_pre got=%0d/%b exp=3/1", bus.count, bus.busy_a); end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (bus.count !== CW'(0)) begin failures++; $display("FAIL rstmid_count got=%0d exp=0", bus.count); end
        checks++; if (bus.mc_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b exp=1", bus.mc_ready); end
        checks++; if (bus.busy_a !== 1'b0 || bus.busy_b !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b%b exp=00", bus.busy_a, bus.busy_b); end
        checks++; if (bus.rf_load !== 1'b0) begin failures++; $display("FAIL rstmid_load got=%b exp=0", bus.rf_load); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++; if (bus.rf_load !== 1'b0 || bus.count !== CW'(0)) begin failures++; $display("FAIL rstmid_stale i=%0d got=%b/%0d exp=0/0", i, bus.rf_load, bus.count); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bus.pipe_valid  = (c < 200) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 4) == 0);
            bus.pipe_dest   = 5'($urandom_range(0, 31));
            bus.pipe_data   = $urandom;
            bus.mc_valid    = ($urandom_range(0, 1) == 1);
            bus.mc_dest     = 5'($urandom_range(0, 31));
            bus.mc_data     = $urandom;
            bus.issue_valid = ($urandom_range(0, 2) == 0);
            bus.issue_dest  = 5'($urandom_range(0, 31));
            bus.busy_src_a  = 5'($urandom_range(0, 31));
            bus.busy_src_b  = 5'($urandom_range(0, 31));
            #1;
            checks++;
            if (bus.mc_ready !== (mq.size() < QD) || bus.busy_a !== m_pend[bus.busy_src_a] || bus.busy_b !== m_pend[bus.busy_src_b]) begin
                failures++;
                $display("FAIL rand_comb c=%0d got=%b/%b/%b exp=%b/%b/%b", c, bus.mc_ready, bus.busy_a, bus.busy_b,
                         (mq.size() < QD), m_pend[bus.busy_src_a], m_pend[bus.busy_src_b]);
            end
            cycle();
            checks++;
            if (bus.rf_load !== m_load || bus.rf_dest !== m_dest || bus.rf_in !== m_in || bus.count !== CW'(mq.size())) begin
                failures++;
                $display("FAIL rand_out c=%0d got=%b/%0d/%h/%0d exp=%b/%0d/%h/%0d", c, bus.rf_load, bus.rf_dest, bus.rf_in, bus.count,
                         m_load, m_dest, m_in, mq.size());
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_pipe_write();
        test_scoreboard();
        test_priority_queue();
        test_x0();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
